// File: rtl/adder_error_sweep_ctrl_if.sv
// Bus between the approximate-adder error sweeper and its environment:
// control, operand drive, adder result and the accumulated error report.
interface adder_error_sweep_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     apx_a;
    logic [WIDTH-1:0]     apx_b;
    logic [WIDTH:0]       apx_sum;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH:0]     viol_cnt;
    logic [WIDTH:0]       max_err;
    logic [3*WIDTH:0]     err_sum;
    logic [2*WIDTH-1:0]   first_viol;
    logic                 first_vld;

    // master: the sweep controller
    modport master (
        input  start, abort, apx_sum,
        output apx_a, apx_b, busy, done, pass, viol_cnt, max_err, err_sum,
               first_viol, first_vld
    );

    // slave: the environment (start/abort source and the adder under test)
    modport slave (
        output start, abort, apx_sum,
        input  apx_a, apx_b, busy, done, pass, viol_cnt, max_err, err_sum,
               first_viol, first_vld
    );
endinterface

// File: rtl/adder_error_sweep_ctrl.sv
// Exhaustive error sweep of a combinational approximate adder: drives every
// {b,a} operand pair, compares the adder result with the exact sum, accumulates stats.
module adder_error_sweep_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ET     = 16,
    parameter int unsigned SETTLE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    adder_error_sweep_ctrl_if.master bus
);
    localparam int unsigned VW = 2 * WIDTH;
    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned DW = WIDTH + 2;
    localparam int unsigned CW = 2 * WIDTH + 1;
    localparam int unsigned EW = 3 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [VW-1:0]   vec;
    logic [3:0]      settle_cnt;
    logic            clear_en;
    logic            accum_en;
    logic            adv_en;

    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [CW-1:0]   viol_cnt_q;
    logic [SW-1:0]   max_err_q;
    logic [EW-1:0]   err_sum_q;
    logic [VW-1:0]   first_viol_q;
    logic            first_vld_q;

    logic [SW-1:0]   exact;
    logic [DW-1:0]   diff;
    logic [SW-1:0]   err;
    logic            viol_hit;

    // Error magnitude of the current vector against the exact sum
    always_comb begin
        exact    = SW'(vec[WIDTH-1:0]) + SW'(vec[VW-1:WIDTH]);
        diff     = {1'b0, bus.apx_sum} - {1'b0, exact};
        err      = diff[DW-1] ? SW'(-diff) : diff[SW-1:0];
        viol_hit = 32'(err) > ET;
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        clear_en  = 1'b0;
        accum_en  = 1'b0;
        adv_en    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    clear_en  = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == 4'(SETTLE)) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    accum_en = 1'b1;
                    if (vec == {VW{1'b1}}) begin
                        state_nxt = DONE;
                    end else begin
                        adv_en    = 1'b1;
                        state_nxt = DRIVE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            vec          <= '0;
            settle_cnt   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            viol_cnt_q   <= '0;
            max_err_q    <= '0;
            err_sum_q    <= '0;
            first_viol_q <= '0;
            first_vld_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy_q     <= (state_nxt == DRIVE) || (state_nxt == SAMPLE);
            done_q     <= (state_nxt == DONE);
            settle_cnt <= (state == DRIVE && state_nxt == DRIVE) ? settle_cnt + 4'd1 : 4'd0;

            if (clear_en) begin
                vec          <= '0;
                pass_q       <= 1'b0;
                viol_cnt_q   <= '0;
                max_err_q    <= '0;
                err_sum_q    <= '0;
                first_viol_q <= '0;
                first_vld_q  <= 1'b0;
            end

            if (adv_en) begin
                vec <= vec + VW'(1);
            end

            if (accum_en) begin
                err_sum_q <= err_sum_q + EW'(err);
                if (err > max_err_q) begin
                    max_err_q <= err;
                end
                if (viol_hit) begin
                    viol_cnt_q <= viol_cnt_q + CW'(1);
                    if (!first_vld_q) begin
                        first_viol_q <= vec;
                        first_vld_q  <= 1'b1;
                    end
                end
            end

            // The last sample's violation must be folded in, since pass is valid with done
            if (state_nxt == DONE) begin
                pass_q <= (viol_cnt_q == '0) && !viol_hit;
            end
        end
    end

    assign bus.apx_a      = vec[WIDTH-1:0];
    assign bus.apx_b      = vec[VW-1:WIDTH];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.viol_cnt   = viol_cnt_q;
    assign bus.max_err    = max_err_q;
    assign bus.err_sum    = err_sum_q;
    assign bus.first_viol = first_viol_q;
    assign bus.first_vld  = first_vld_q;

endmodule

// File: tb/tb_adder_error_sweep_ctrl.sv
// Self-checking bench for adder_error_sweep_ctrl: stand-in adders (exact, tied
// to 0, tied to 31) behind a SETTLE=0 instance, plus an exact-adder SETTLE=2 instance.
module tb_adder_error_sweep_ctrl;
    localparam int unsigned WIDTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;

    adder_error_sweep_ctrl_if #(.WIDTH(WIDTH)) ifc0 ();
    adder_error_sweep_ctrl_if #(.WIDTH(WIDTH)) ifc2 ();

    adder_error_sweep_ctrl #(.WIDTH(WIDTH), .ET(16), .SETTLE(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.master)
    );

    adder_error_sweep_ctrl #(.WIDTH(WIDTH), .ET(16), .SETTLE(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (ifc2.master)
    );

    // Stand-in adders: 0 exact, 1 tied to 0, 2 tied to all-ones
    assign ifc0.apx_sum = (mode == 2'd0) ? 5'(ifc0.apx_a) + 5'(ifc0.apx_b) :
                          (mode == 2'd1) ? 5'd0 : 5'd31;
    assign ifc2.apx_sum = 5'(ifc2.apx_a) + 5'(ifc2.apx_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] mode;
        int         viol;
        int         maxe;
        int         esum;
        int         first;
        int         vld;
        int         pass;
    } sweep_vec_t;

    sweep_vec_t tbl [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({ifc0.busy, ifc0.done, ifc0.pass, ifc0.viol_cnt, ifc0.max_err,
                       ifc0.first_vld, ifc0.first_viol, ifc0.apx_a, ifc0.apx_b}), 32'd0);
        chk({name, "_err_sum"}, 32'(ifc0.err_sum), 32'd0);
    endtask

    // Start a sweep on the SETTLE=0 instance and wait (bounded) for done
    task automatic sweep0(output int lat, output int v0, output int vc0);
        int  t0;
        bit  got;
        @(negedge clk); ifc0.start = 1'b1;
        @(negedge clk); ifc0.start = 1'b0;
        t0  = cyc;
        v0  = int'({ifc0.apx_b, ifc0.apx_a});
        vc0 = int'(ifc0.viol_cnt);
        chk("busy_first", 32'(ifc0.busy), 32'd1);
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (ifc0.done) begin
                got = 1'b1;
                lat = cyc - t0;
            end
        end
    endtask

    task automatic chk_results(input string tag, input sweep_vec_t e);
        chk({tag, "_viol"},  32'(ifc0.viol_cnt),   32'(e.viol));
        chk({tag, "_max"},   32'(ifc0.max_err),    32'(e.maxe));
        chk({tag, "_sum"},   32'(ifc0.err_sum),    32'(e.esum));
        chk({tag, "_first"}, 32'(ifc0.first_viol), 32'(e.first));
        chk({tag, "_vld"},   32'(ifc0.first_vld),  32'(e.vld));
        chk({tag, "_pass"},  32'(ifc0.pass),       32'(e.pass));
    endtask

    initial begin
        int  lat, v0, vc0, t0, run, bad, prev;
        bit  hit, got, seen_done;

        tbl[0] = '{mode: 2'd0, viol: 0,   maxe: 0,  esum: 0,    first: 0,    vld: 0, pass: 1};
        tbl[1] = '{mode: 2'd1, viol: 105, maxe: 30, esum: 3840, first: 'h2F, vld: 1, pass: 0};
        tbl[2] = '{mode: 2'd2, viol: 120, maxe: 31, esum: 4096, first: 'h00, vld: 1, pass: 0};

        rst = 1'b1; mode = 2'd0;
        ifc0.start = 1'b0; ifc0.abort = 1'b0;
        ifc2.start = 1'b0; ifc2.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(ifc0.busy), 32'd0);

        // T1..T3: full sweeps against the stand-in adders
        for (int k = 0; k < 3; k++) begin
            mode = tbl[k].mode;
            sweep0(lat, v0, vc0);
            chk($sformatf("t%0d_latency", k + 1), 32'(lat), 32'd512);
            chk_results($sformatf("t%0d", k + 1), tbl[k]);
            @(negedge clk);
            chk($sformatf("t%0d_done_one_cycle", k + 1), 32'(ifc0.done), 32'd0);
            chk($sformatf("t%0d_pass_held", k + 1), 32'(ifc0.pass), 32'(tbl[k].pass));
        end

        // T4: abort at vector 100 keeps partial results, restart clears them
        mode = 2'd1;
        @(negedge clk); ifc0.start = 1'b1;
        @(negedge clk); ifc0.start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if ({ifc0.apx_b, ifc0.apx_a} == 8'd100) hit = 1'b1;
            else @(negedge clk);
        end
        chk("t4_reach_v100", 32'(hit), 32'd1);
        ifc0.abort = 1'b1;
        @(negedge clk); ifc0.abort = 1'b0;
        chk("t4_busy_after_abort", 32'(ifc0.busy), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ifc0.done) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("t4_no_done", 32'(seen_done), 32'd0);
        chk("t4_partial_viol", 32'(ifc0.viol_cnt), 32'd10);
        chk("t4_partial_max",  32'(ifc0.max_err),  32'd20);
        chk("t4_partial_sum",  32'(ifc0.err_sum),  32'd990);
        sweep0(lat, v0, vc0);
        chk("t4_restart_v0", 32'(v0), 32'd0);
        chk("t4_restart_clear", 32'(vc0), 32'd0);
        chk("t4_latency", 32'(lat), 32'd512);
        chk_results("t4", tbl[1]);

        // start and abort together in IDLE: abort wins, results untouched
        @(negedge clk); ifc0.start = 1'b1; ifc0.abort = 1'b1;
        @(negedge clk); ifc0.start = 1'b0; ifc0.abort = 1'b0;
        chk("t6_startabort_busy", 32'(ifc0.busy), 32'd0);
        @(negedge clk);
        chk("t6_startabort_idle", 32'(ifc0.busy), 32'd0);
        chk("t6_startabort_viol", 32'(ifc0.viol_cnt), 32'd105);
        chk("t6_startabort_max",  32'(ifc0.max_err),  32'd30);

        // T5: SETTLE=2, restart pulse mid-sweep ignored, 4 cycles per vector
        @(negedge clk); ifc2.start = 1'b1;
        @(negedge clk); ifc2.start = 1'b0;
        t0   = cyc;
        prev = int'({ifc2.apx_b, ifc2.apx_a});
        chk("t5_v0", 32'(prev), 32'd0);
        run  = 1; bad = 0; got = 1'b0; lat = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (i == 100) ifc2.start = 1'b1;
            else if (i == 101) ifc2.start = 1'b0;
            if (ifc2.done) begin
                got = 1'b1;
                lat = cyc - t0;
                if (run != 4) bad++;
            end else if (int'({ifc2.apx_b, ifc2.apx_a}) != prev) begin
                if (run != 4) bad++;
                prev = int'({ifc2.apx_b, ifc2.apx_a});
                run  = 1;
            end else begin
                run++;
            end
        end
        chk("t5_latency", 32'(lat), 32'd1024);
        chk("t5_operand_hold", 32'(bad), 32'd0);
        chk("t5_pass", 32'(ifc2.pass), 32'd1);
        chk("t5_viol", 32'(ifc2.viol_cnt), 32'd0);

        // T6: reset in the middle of a sweep
        mode = 2'd1;
        @(negedge clk); ifc0.start = 1'b1;
        @(negedge clk); ifc0.start = 1'b0;
        repeat (300) @(negedge clk);
        chk("t6_mid_busy", 32'(ifc0.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_all_zero("t6_reset");
        @(negedge clk);
        chk("t6_post_reset_idle", 32'(ifc0.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
